uart_tx_top: RTL and testbench

//   UART transmitter: accepts a parallel byte with a one-cycle data_valid strobe and

---
 rtl/uart_tx_top.sv | 116 +++++++++++
 tb/tb_uart_tx_top.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// uart_tx_top: one-bit-per-clock UART transmitter.
// A frame is start(0), DATA_WIDTH data bits LSB-first, an optional parity bit,
// and stop(1). tx_out and busy are registered from the FSM state, so the line
// lags the state machine by exactly one clock.
module uart_tx_top #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    tx_out_q, tx_out_d;
  logic                    busy_q, busy_d;
  logic                    parity_bit;

  // Parity over the latched byte: even -> XOR of bits, odd -> its inverse.
  assign parity_bit = par_typ_q ? ~(^data_q) : (^data_q);

  // Next-state logic; the frame parameters are latched only on acceptance in IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          state_d   = ST_START;
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output mux: the line level and busy flag that the current state calls for.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:   tx_out_d = 1'b1;
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = data_q[cnt_q];
      ST_PARITY: tx_out_d = parity_bit;
      ST_STOP:   tx_out_d = 1'b1;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Testbench for uart_tx_top: directed frames with known bit patterns plus a
// randomized run, all compared against a frame-level reference model.
module tb_uart_tx_top;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  uart_tx_top #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the line levels still to be emitted, one per edge, and the
  // first edge at which the transmitter can accept a new byte.
  bit exp_q[$];
  int edge_n    = 0;
  int free_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    free_edge = 0;
  endtask

  // Queue a whole frame: start, data LSB-first, optional parity, stop.
  task automatic model_accept(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) begin
      ones = $countones(d);
      // even parity makes the total count of ones even; odd makes it odd
      exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    end
    exp_q.push_back(1'b1);
    // The line shows bits at edges N+1..N+L; the next byte can be taken at N+L+1.
    free_edge = edge_n + exp_q.size() + 1;
  endtask

  // One clock: advance the model with the inputs sampled at this edge, then
  // compare tx_out and busy just after the edge.
  task automatic tick();
    logic exp_tx;
    logic exp_busy;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_reset();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        exp_tx   = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      if (data_valid && edge_n >= free_edge) model_accept(p_data, par_en, par_typ);
    end
    #1;
    check($sformatf("tx_out@%0d", edge_n), 32'(tx_out), 32'(exp_tx));
    check($sformatf("busy@%0d", edge_n), 32'(busy), 32'(exp_busy));
  endtask

  // Strobe one byte from IDLE, scramble the inputs afterwards, and record the
  // 11 line levels following acceptance plus the number of busy cycles.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            output logic [0:10] bits, output int nbusy);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    p_data     = ~d;
    par_en     = ~pe;
    par_typ    = ~pt;
    nbusy      = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 11) bits[i] = tx_out;
      if (busy) nbusy++;
    end
  endtask

  logic [0:10] bits;
  logic [0:21] bb;
  int          nbusy;

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #1;
    check("reset_tx", 32'(tx_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    model_reset();

    // Idle line stays high and not busy.
    repeat (6) tick();

    // 8'h69 without parity.
    send_frame(8'h69, 1'b0, 1'b0, bits, nbusy);
    check("frame_69", 32'(bits[0:9]), 32'(10'b0100101101));
    check("busy_len_69", 32'(nbusy), 32'd10);

    // 8'h96 with even parity.
    send_frame(8'h96, 1'b1, 1'b0, bits, nbusy);
    check("frame_96_even", 32'(bits), 32'(11'b00110100101));
    check("busy_len_96", 32'(nbusy), 32'd11);

    // Parity bit position 9 for assorted bytes.
    send_frame(8'h1E, 1'b1, 1'b1, bits, nbusy);
    check("parity_1E_odd", 32'(bits[9]), 32'd1);
    send_frame(8'hC3, 1'b1, 1'b1, bits, nbusy);
    check("parity_C3_odd", 32'(bits[9]), 32'd1);
    send_frame(8'h7B, 1'b1, 1'b0, bits, nbusy);
    check("parity_7B_even", 32'(bits[9]), 32'd0);

    // Strobe mid-frame with a different byte: must be ignored.
    p_data     = 8'h55;
    par_en     = 1'b0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
        par_en     = 1'b1;
      end
      tick();
      data_valid = 1'b0;
      if (i < 11) bits[i] = tx_out;
    end
    check("frame_55_ignore", 32'(bits[0:9]), 32'(10'b0101010101));
    check("idle_after_55", 32'(bits[10]), 32'd1);

    // data_valid held high: a new frame starts on each first IDLE edge.
    p_data     = 8'hA5;
    par_en     = 1'b0;
    data_valid = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      tick();
      bb[i] = tx_out;
    end
    data_valid = 1'b0;
    check("back_to_back_A5", 32'(bb), 32'(22'b0101001011101010010111));
    repeat (14) tick();

    // Reset during a data bit aborts the frame immediately.
    p_data     = 8'h3C;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    send_frame(8'h96, 1'b1, 1'b0, bits, nbusy);
    check("frame_96_after_rst", 32'(bits), 32'(11'b00110100101));

    // Randomized traffic: sporadic strobes, inputs changing every cycle.
    for (int i = 0; i < 400; i++) begin
      data_valid = ($urandom_range(0, 5) == 0);
      p_data     = 8'($urandom);
      par_en     = 1'($urandom_range(0, 1));
      par_typ    = 1'($urandom_range(0, 1));
      tick();
    end
    data_valid = 1'b0;
    repeat (14) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
